pulse_gen_bank: RTL and testbench

Parametrised multi-channel one-shot pulse generator for the scoreboard's operator push-buttons (ball, strike, out, inning advance, …). Each channel synchronises an asynchronous button level, detects the selected edge, and emits a clean registered pulse of programmable width, so downstream counters advance exactly once per press. It adds per-channel miss flags and an optional hold-to-repeat feature, and replaces the single-channel, rising-edge, one-cycle pulse generator.

---
 rtl/pulse_gen_bank.sv | 181 ++++++++++++++++++
 tb/tb_pulse_gen_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_bank.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gen_bank
//  Purpose  : Multi-channel one-shot pulse generator for operator push-buttons
//             with edge select, sticky miss flags and optional auto-repeat
//             (compile-time macro PG_AUTOREPEAT_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_gen_bank #(
   parameter int CH          = 4,
   parameter int PW          = 2,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 20,
   parameter int RPT_CYCLES  = 6
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic [CH-1:0] iEN,
   input  logic [1:0]    iMODE,
   input  logic          iCLR,
   output logic [CH-1:0] oP,
   output logic [CH-1:0] oBUSY,
   output logic [CH-1:0] oMISS
);
   localparam int               c_PCW      = $clog2(PW + 1);
   localparam logic [c_PCW-1:0] c_PW_LOAD  = c_PCW'(PW - 1);
   localparam logic [1:0]       c_IDLE     = 2'd0;
   localparam logic [1:0]       c_PULSE    = 2'd1;
   localparam logic [1:0]       c_MODE_RISE = 2'b00;
   localparam logic [1:0]       c_MODE_FALL = 2'b01;
   localparam logic [1:0]       c_MODE_BOTH = 2'b10;
   localparam logic [1:0]       c_MODE_OFF  = 2'b11;
`ifdef PG_AUTOREPEAT_EN
   localparam logic [1:0]       c_ARM       = 2'd2;
   localparam int               c_HMAX      = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
   localparam int               c_HCW       = $clog2(c_HMAX + 1);
   localparam logic [c_HCW-1:0] c_HOLD_LOAD = c_HCW'(HOLD_CYCLES - 1);
   localparam logic [c_HCW-1:0] c_RPT_LOAD  = c_HCW'(RPT_CYCLES - 1);
`endif

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic             w_s;
      logic             r_prev;
      logic             w_rise;
      logic             w_fall;
      logic             w_event;
      logic [1:0]       r_state;
      logic [1:0]       w_nextState;
      logic [c_PCW-1:0] r_pcnt;
      logic [c_PCW-1:0] w_nextPcnt;
      logic             r_p;
      logic             r_busy;
      logic             r_miss;
      logic             w_pNext;
      logic             w_busyNext;
      logic             w_missNext;
`ifdef PG_AUTOREPEAT_EN
      logic [c_HCW-1:0] r_hcnt;
      logic [c_HCW-1:0] w_nextHcnt;
`endif

      if (SYNC_STAGES == 0) begin : g_bypass
         assign w_s = iEN[gi];
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;
         always_ff @(posedge iCLK or posedge iRST) begin
            if (iRST) r_sync <= '0;
            else      r_sync <= (r_sync << 1) | SYNC_STAGES'(iEN[gi]);
         end
         assign w_s = r_sync[SYNC_STAGES-1];
      end

      assign w_rise = w_s & ~r_prev;
      assign w_fall = ~w_s & r_prev;

      always_comb begin
         case (iMODE)
            c_MODE_RISE: w_event = w_rise;
            c_MODE_FALL: w_event = w_fall;
            c_MODE_BOTH: w_event = w_rise | w_fall;
            default:     w_event = 1'b0;
         endcase
      end

      // State register; pulse/busy/miss are registered so they leave straight from flops.
      always_ff @(posedge iCLK or posedge iRST) begin
         if (iRST) begin
            r_prev  <= 1'b0;
            r_state <= c_IDLE;
            r_pcnt  <= '0;
            r_p     <= 1'b0;
            r_busy  <= 1'b0;
            r_miss  <= 1'b0;
`ifdef PG_AUTOREPEAT_EN
            r_hcnt  <= '0;
`endif
         end else begin
            r_prev  <= w_s;
            r_state <= w_nextState;
            r_pcnt  <= w_nextPcnt;
            r_p     <= w_pNext;
            r_busy  <= w_busyNext;
            r_miss  <= w_missNext;
`ifdef PG_AUTOREPEAT_EN
            r_hcnt  <= w_nextHcnt;
`endif
         end
      end

      always_comb begin
         w_nextState = r_state;
         w_nextPcnt  = r_pcnt;
`ifdef PG_AUTOREPEAT_EN
         w_nextHcnt  = r_hcnt;
`endif
         case (r_state)
            c_IDLE: begin
               if (w_event) begin
                  w_nextState = c_PULSE;
                  w_nextPcnt  = c_PW_LOAD;
`ifdef PG_AUTOREPEAT_EN
                  w_nextHcnt  = c_HOLD_LOAD;
`endif
               end
            end
            c_PULSE: begin
`ifdef PG_AUTOREPEAT_EN
               if (r_hcnt != '0) w_nextHcnt = r_hcnt - 1'b1;
`endif
               if (r_pcnt == '0) begin
`ifdef PG_AUTOREPEAT_EN
                  if ((iMODE == c_MODE_RISE || iMODE == c_MODE_BOTH) && w_s)
                     w_nextState = c_ARM;
                  else
                     w_nextState = c_IDLE;
`else
                  w_nextState = c_IDLE;
`endif
               end else begin
                  w_nextPcnt = r_pcnt - 1'b1;
               end
            end
`ifdef PG_AUTOREPEAT_EN
            c_ARM: begin
               if (iMODE == c_MODE_OFF) begin
                  w_nextState = c_IDLE;
               end else if (!w_s) begin
                  // Release while armed is still a real event in both-edge mode.
                  if (iMODE == c_MODE_BOTH && w_fall) begin
                     w_nextState = c_PULSE;
                     w_nextPcnt  = c_PW_LOAD;
                     w_nextHcnt  = c_HOLD_LOAD;
                  end else begin
                     w_nextState = c_IDLE;
                  end
               end else if (r_hcnt == '0) begin
                  w_nextState = c_PULSE;
                  w_nextPcnt  = c_PW_LOAD;
                  w_nextHcnt  = c_RPT_LOAD;
               end else begin
                  w_nextHcnt = r_hcnt - 1'b1;
               end
            end
`endif
            default: w_nextState = c_IDLE;
         endcase
      end

      always_comb begin
         w_pNext    = (w_nextState == c_PULSE);
         w_busyNext = (w_nextState != c_IDLE);
         // A new miss takes priority over a coincident clear.
         w_missNext = (r_miss & ~iCLR) | ((r_state == c_PULSE) & w_event);
      end

      assign oP[gi]    = r_p;
      assign oBUSY[gi] = r_busy;
      assign oMISS[gi] = r_miss;
   end
endmodule
`default_nettype wire

// File: tb/tb_pulse_gen_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_gen_bank
//  Purpose  : Directed self-checking bench for pulse_gen_bank (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_gen_bank;
   localparam int CH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] en = '0;
   logic [1:0]    mode = 2'b00;
   logic          clr = 1'b0;
   logic [CH-1:0] p;
   logic [CH-1:0] busy;
   logic [CH-1:0] miss;
   int            nChecks = 0;
   int            nFails = 0;

   pulse_gen_bank #(
      .CH(CH), .PW(2), .SYNC_STAGES(2), .HOLD_CYCLES(20), .RPT_CYCLES(6)
   ) dut (
      .iCLK(clk), .iRST(rst), .iEN(en), .iMODE(mode), .iCLR(clr),
      .oP(p), .oBUSY(busy), .oMISS(miss)
   );

   always #5 clk = ~clk;

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = '0; mode = 2'b00; clr = 1'b0;
      idle(3);
      nChecks++; if (p !== 4'b0000) begin nFails++; $display("FAIL reset_p: got %b want 0000", p); end
      nChecks++; if (busy !== 4'b0000) begin nFails++; $display("FAIL reset_busy: got %b want 0000", busy); end
      nChecks++; if (miss !== 4'b0000) begin nFails++; $display("FAIL reset_miss: got %b want 0000", miss); end
      rst = 1'b0;
      idle(5);
      nChecks++; if (p !== 4'b0000 || busy !== 4'b0000) begin nFails++; $display("FAIL post_reset_idle: p=%b busy=%b want 0000", p, busy); end
   endtask

   task automatic test_rising();
      logic [7:0] expP = 8'b0000_1100;
      logic [3:0] want;
      mode = 2'b00;
      en[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         want = expP[k] ? 4'b0001 : 4'b0000;
         nChecks++; if (p !== want) begin nFails++; $display("FAIL rising_k%0d: p=%b want %b", k, p, want); end
         if (k == 4) en[0] = 1'b0;
      end
      nChecks++; if (miss !== 4'b0000) begin nFails++; $display("FAIL rising_miss: got %b want 0000", miss); end
      idle(30);
   endtask

   task automatic test_both();
      logic [13:0] expP = 14'b00_1100_0000_1100;
      logic [3:0]  want;
      mode = 2'b10;
      en[1] = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         want = expP[k] ? 4'b0010 : 4'b0000;
         nChecks++; if (p !== want) begin nFails++; $display("FAIL both_k%0d: p=%b want %b", k, p, want); end
         if (k == 2) begin
            nChecks++; if (busy[1] !== 1'b1) begin nFails++; $display("FAIL both_busy: got %b want 1", busy[1]); end
         end
         if (k == 7) en[1] = 1'b0;
      end
      idle(30);
   endtask

   task automatic test_miss();
      mode = 2'b10;
      // Rise then fall one cycle later: the fall lands inside the pulse.
      en[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 2 || k == 3) begin
            nChecks++; if (p[1] !== 1'b1) begin nFails++; $display("FAIL miss_pulse_k%0d: p1=%b want 1", k, p[1]); end
         end
         if (k == 4) begin
            nChecks++; if (p[1] !== 1'b0) begin nFails++; $display("FAIL miss_not_extended: p1=%b want 0", p[1]); end
         end
         if (k == 2) begin
            nChecks++; if (miss !== 4'b0000) begin nFails++; $display("FAIL miss_early: got %b want 0000", miss); end
         end
         if (k == 3) begin
            nChecks++; if (miss !== 4'b0010) begin nFails++; $display("FAIL miss_set: got %b want 0010", miss); end
         end
         if (k == 0) en[1] = 1'b0;
      end
      idle(10);
      // Same again with a clear coincident with the new miss.
      en[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 3 || k == 5) begin
            nChecks++; if (miss[1] !== 1'b1) begin nFails++; $display("FAIL miss_clr_coincident_k%0d: got %b want 1", k, miss[1]); end
         end
         if (k == 0) en[1] = 1'b0;
         clr = (k == 2);
      end
      clr = 1'b0;
      idle(5);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      nChecks++; if (miss !== 4'b0000) begin nFails++; $display("FAIL miss_lone_clr: got %b want 0000", miss); end
      idle(10);
   endtask

   task automatic test_disabled();
      logic [6:0] expP = 7'b000_1100;
      logic [3:0] want;
      mode = 2'b11;
      for (int k = 0; k < 10; k++) begin
         en = k[1] ? 4'hF : 4'h0;
         @(negedge clk);
         nChecks++; if (p !== 4'b0000 || busy !== 4'b0000) begin nFails++; $display("FAIL disabled_k%0d: p=%b busy=%b want 0000", k, p, busy); end
      end
      en = '0;
      idle(5);
      mode = 2'b00;
      en[3] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         want = expP[k] ? 4'b1000 : 4'b0000;
         nChecks++; if (p !== want) begin nFails++; $display("FAIL mode_change_k%0d: p=%b want %b", k, p, want); end
         if (k == 2) mode = 2'b11;
      end
      en[3] = 1'b0;
      idle(30);
      mode = 2'b00;
      idle(3);
   endtask

   task automatic test_simultaneous();
      logic [5:0] expP = 6'b00_1100;
      logic [3:0] want;
      mode = 2'b00;
      en = 4'hF;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         want = expP[k] ? 4'hF : 4'h0;
         nChecks++; if (p !== want) begin nFails++; $display("FAIL simul_rise_k%0d: p=%b want %b", k, p, want); end
      end
      en = '0;
      idle(10);
      mode = 2'b01;
      en = 4'hF;
      idle(5);
      nChecks++; if (p !== 4'h0) begin nFails++; $display("FAIL fallmode_rise_ignored: p=%b want 0000", p); end
      en = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         want = expP[k] ? 4'hF : 4'h0;
         nChecks++; if (p !== want) begin nFails++; $display("FAIL simul_fall_k%0d: p=%b want %b", k, p, want); end
      end
      idle(10);
      mode = 2'b00;
   endtask

   task automatic test_repeat();
      int   rises[$];
      int   nHigh = 0;
      logic last = 1'b0;
`ifdef PG_AUTOREPEAT_EN
      int   expRel[5] = '{0, 20, 26, 32, 38};
      int   expHigh = 10;
`else
      int   expRel[1] = '{0};
      int   expHigh = 2;
`endif
      mode = 2'b00;
      en[2] = 1'b1;
      for (int k = 0; k < 56; k++) begin
         @(negedge clk);
         if (p[2] && !last) rises.push_back(k);
         if (p[2]) nHigh++;
         last = p[2];
         if (k == 39) en[2] = 1'b0;
      end
      nChecks++; if (rises.size() !== $size(expRel)) begin nFails++; $display("FAIL repeat_count: got %0d want %0d", rises.size(), $size(expRel)); end
      nChecks++; if (nHigh !== expHigh) begin nFails++; $display("FAIL repeat_high_cycles: got %0d want %0d", nHigh, expHigh); end
      if (rises.size() > 0) begin
         nChecks++; if (rises[0] !== 2) begin nFails++; $display("FAIL repeat_first_latency: got %0d want 2", rises[0]); end
         for (int i = 1; i < rises.size() && i < $size(expRel); i++) begin
            nChecks++; if (rises[i] - rises[0] !== expRel[i]) begin nFails++; $display("FAIL repeat_rise%0d: got %0d want %0d", i, rises[i] - rises[0], expRel[i]); end
         end
      end
      idle(10);
      nChecks++; if (busy !== 4'b0000 || p !== 4'b0000) begin nFails++; $display("FAIL repeat_release_idle: busy=%b p=%b want 0000", busy, p); end
   endtask

   task automatic test_reset_mid();
      logic [10:0] expP = 11'b000_0000_1100;
      int          nHigh = 0;
      logic [3:0]  want;
      mode = 2'b00;
      en[0] = 1'b1;
      idle(3);
      nChecks++; if (p[0] !== 1'b1) begin nFails++; $display("FAIL rstmid_pulse_up: p0=%b want 1", p[0]); end
      #2 rst = 1'b1;
      #1;
      nChecks++; if (p !== 4'b0000 || busy !== 4'b0000) begin nFails++; $display("FAIL rstmid_async_drop: p=%b busy=%b want 0000", p, busy); end
      idle(3);
      rst = 1'b0;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         want = expP[k] ? 4'b0001 : 4'b0000;
         if (p[0]) nHigh++;
         nChecks++; if (p !== want) begin nFails++; $display("FAIL rstmid_release_k%0d: p=%b want %b", k, p, want); end
      end
      nChecks++; if (nHigh !== 2) begin nFails++; $display("FAIL rstmid_one_pulse: high=%0d want 2", nHigh); end
      en = '0;
      idle(10);
   endtask

   initial begin
      test_reset();
      test_rising();
      test_both();
      test_miss();
      test_disabled();
      test_simultaneous();
      test_repeat();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
`default_nettype wire
